iomem_bus_ctrl: RTL
===================

// Module: iomem_bus_ctrl
// PURPOSE
//  Sequencer/decoder between picosoc iomem master and up to NUM_SLOTS peripheral slots.
//  Decodes iomem_addr[31:24] into a one-hot slot select and holds the transaction
//  until the slot returns ready. Ends hung or unmapped accesses with an error word.
//  Replaces the per-peripheral ready/rdata muxing in top; every peripheral sees one clean strobe.
// PARAMETERS
//  NUM_SLOTS  8        number of peripheral slots (1..16)
//  BASE_PAGE  8'h03    addr[31:24] value of slot 0; slot k = BASE_PAGE+k
//  TIMEOUT    255      cycles ACCESS may wait for periph_ready before error (1..65535)
//  ERR_DATA   32'hDEADBEEF  rdata returned on unmapped/timeout access
// PORTS
//  clk            in   1            system clock
//  resetn         in   1            async active-low reset
//  iomem_valid    in   1            CPU request
//  iomem_ready    out  1            one-cycle completion pulse to CPU
//  iomem_wstrb    in   4            byte strobes; 0 = read
//  iomem_addr     in   32           CPU address
//  iomem_wdata    in   32           CPU write data
//  iomem_rdata    out  32           read data, valid when iomem_ready=1
//  periph_sel     out  NUM_SLOTS    one-hot slot select, held for the whole access
//  periph_wstrb   out  4            latched strobes, shared by all slots
//  periph_addr    out  8            latched iomem_addr[7:0], shared
//  periph_wdata   out  32           latched write data, shared
//  periph_ready   in   NUM_SLOTS    per-slot done; only selected bit is honoured
//  periph_rdata   in   32*NUM_SLOTS flattened per-slot read data, slot k at [32k+31:32k]
//  err_count      out  8            saturating count of error completions
//  err_addr       out  32           address of most recent error completion
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (iomem_ready, iomem_rdata, periph_*, err_count, err_addr).
//  States IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP directly for unmapped.
//  IDLE: on iomem_valid && !iomem_ready, latch addr/wstrb/wdata; idx = addr[31:24]-BASE_PAGE
//   (8-bit wrap). idx<NUM_SLOTS: periph_sel[idx]<=1, timer<=0, go ACCESS.
//   Else: rdata<=ERR_DATA, err update, go RESP.
//  ACCESS: sel held. periph_ready[idx]=1: rdata<=periph_rdata[idx], sel<=0, go RESP.
//   Else timer increments; timer==TIMEOUT-1 with no ready: sel<=0, rdata<=ERR_DATA,
//   err update, go RESP. Ready and timeout in same cycle: ready wins, no error.
//  RESP: iomem_ready=1 exactly one cycle, then IDLE. Requests not re-accepted that cycle.
//  Latency (zero-wait slot): valid sampled T0, sel high T1, ready sampled T1, iomem_ready T2.
//  Unmapped: iomem_ready at T1.
//  Writes: rdata returned as slot gives it (CPU ignores). Unselected periph_ready bits ignored.
//  Err update: err_count <= (err_count==255) ? 255 : err_count+1; err_addr <= latched addr.
//  iomem_valid dropping mid-ACCESS: access still completes and ready still pulses.
//  Async reset mid-access: sel drops immediately, no ready pulse, counters cleared.
// STRUCTURE
//  iomem_defs.vh: state encodings (IDLE/ACCESS/RESP), ERR_DATA default, slot page map
//   (GPIO 03, AUDIO 04, VIDEO 05, I2C 07) for top and firmware headers.
//  Sub-module iomem_watchdog: loadable up-counter, clear/enable in, expired out,
//   width $clog2(TIMEOUT+1). Remaining FSM, latches and rdata mux stay in this module.
// TESTING
//  1 Read slot 0 (addr 0x0300_0004), slot returns ready same cycle with 0x0000_00A5
//    -> periph_sel=8'h01 one cycle; iomem_ready 2 cycles after valid; rdata=0xA5.
//  2 Write 0x1234_5678 wstrb=4'hF to 0x0400_0000, slot 1 ready after 3 wait cycles
//    -> periph_wstrb=F, periph_wdata=0x12345678; sel=8'h02 held 4 cycles; one ready pulse.
//  3 Access 0x0B00_0000 (idx 8, unmapped) -> ready next cycle, rdata=0xDEADBEEF,
//    err_count 0->1, err_addr=0x0B00_0000, no sel asserted.
//  4 Slot 2 never ready, TIMEOUT=16 -> sel dropped after 16 cycles, rdata=ERR_DATA, err_count+1.
//    Repeat with ready on the final cycle -> real data, no error.
//  5 Drive 256 unmapped accesses -> err_count saturates at 255; next access still completes.
//  6 Assert resetn=0 mid-ACCESS -> periph_sel=0 and iomem_ready=0 immediately, err_count=0;
//    after release a fresh read to slot 0 completes normally.
//    Also: pulse a non-selected periph_ready bit -> ignored.

Source files
------------

// File: rtl/iomem_bus_ctrl_pkg.sv
// Shared types for the iomem sequencer: FSM state encoding, error word, page map.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iomem_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Word returned to the CPU on an unmapped or hung access.
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

   // addr[31:24] page of each fixed peripheral; firmware headers mirror this.
   typedef enum logic [7:0] {
      PAGE_GPIO  = 8'h03,
      PAGE_AUDIO = 8'h04,
      PAGE_VIDEO = 8'h05,
      PAGE_I2C   = 8'h07
   } page_t;

   // Error counter sticks at its maximum instead of wrapping.
   function automatic logic [7:0] err_count_next(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
   endfunction

endpackage

// File: rtl/iomem_bus_ctrl_if.sv
// iomem CPU request/response plus shared peripheral slot bus, bundled as one port.
// Latency: n/a (wires only).
// Backpressure: CPU waits for iomem_ready; slots stall via periph_ready.
// master: CPU + peripheral side (drives requests and slot responses).
// slave : the controller (drives completion, slot select and latched request).
interface iomem_bus_ctrl_if #(
   parameter int NUM_SLOTS = 8
);
   logic                      iomem_valid;
   logic                      iomem_ready;
   logic [3:0]                iomem_wstrb;
   logic [31:0]               iomem_addr;
   logic [31:0]               iomem_wdata;
   logic [31:0]               iomem_rdata;
   logic [NUM_SLOTS-1:0]      periph_sel;
   logic [3:0]                periph_wstrb;
   logic [7:0]                periph_addr;
   logic [31:0]               periph_wdata;
   logic [NUM_SLOTS-1:0]      periph_ready;
   logic [32*NUM_SLOTS-1:0]   periph_rdata;

   modport master (
      output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, periph_ready, periph_rdata,
      input  iomem_ready, iomem_rdata, periph_sel, periph_wstrb, periph_addr, periph_wdata
   );

   modport slave (
      input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, periph_ready, periph_rdata,
      output iomem_ready, iomem_rdata, periph_sel, periph_wstrb, periph_addr, periph_wdata
   );
endinterface

// File: rtl/iomem_bus_ctrl_watchdog.sv
// Access watchdog: up-counter cleared outside an access, flags the last allowed wait cycle.
// Latency: expired is combinational from the count; count updates one cycle after enable.
// Backpressure: none; clear has priority over enable.
// Ports: clk, resetn, clear, enable in; expired out.
module iomem_bus_ctrl_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Count starts at 0 on the first wait cycle, so TIMEOUT-1 marks wait cycle number TIMEOUT.
   assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/iomem_bus_ctrl.sv
// Decodes iomem_addr[31:24] into a one-hot slot select and holds it until the slot is ready.
// Latency: zero-wait slot completes 2 cycles after valid; unmapped 1 cycle; hung slot TIMEOUT+1.
// Backpressure: CPU is held until iomem_ready; slots stall with periph_ready up to TIMEOUT cycles.
// Ports: clk, resetn, bus (iomem + periph signals, slave view), err_count, err_addr.
module iomem_bus_ctrl
   import iomem_bus_ctrl_pkg::*;
#(
   parameter int          NUM_SLOTS = 8,
   parameter logic [7:0]  BASE_PAGE = PAGE_GPIO,
   parameter int          TIMEOUT   = 255,
   parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
   input  logic            clk,
   input  logic            resetn,
   iomem_bus_ctrl_if.slave bus,
   output logic [7:0]      err_count,
   output logic [31:0]     err_addr
);

   state_t                state_q;
   state_t                state_d;
   logic [31:0]           addr_q;
   logic [7:0]            page_idx;
   logic                  mapped;
   logic                  accept;
   logic                  hit;
   logic                  expired;
   logic                  wd_clear;
   logic                  wd_enable;
   logic [NUM_SLOTS-1:0]  decode_sel;
   logic [31:0]           slot_rdata;

   // Page offset wraps in 8 bits, so pages below BASE_PAGE land far out of range.
   assign page_idx = bus.iomem_addr[31:24] - BASE_PAGE;
   assign mapped   = (page_idx < 8'(NUM_SLOTS));
   assign accept   = (state_q == ST_IDLE) && bus.iomem_valid && !bus.iomem_ready;

   // Only the selected slot's ready counts; sel is zero outside ACCESS.
   assign hit = |(bus.periph_ready & bus.periph_sel);

   always_comb begin
      decode_sel = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         decode_sel[k] = (page_idx == 8'(k));
      end
   end

   // AND-OR mux keyed by the held one-hot select, so no slot index needs storing.
   always_comb begin
      slot_rdata = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         if (bus.periph_sel[k]) begin
            slot_rdata = slot_rdata | bus.periph_rdata[k*32 +: 32];
         end
      end
   end

   assign wd_clear  = (state_q != ST_ACCESS);
   assign wd_enable = (state_q == ST_ACCESS);

   iomem_bus_ctrl_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .resetn  (resetn),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (expired)
   );

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = mapped ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            if (hit || expired) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: completion pulse is exactly the single RESP cycle.
   always_comb begin
      bus.iomem_ready = (state_q == ST_RESP);
   end

   // Request latches, slot select, response data and error bookkeeping.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q           <= '0;
         bus.periph_sel   <= '0;
         bus.periph_wstrb <= '0;
         bus.periph_addr  <= '0;
         bus.periph_wdata <= '0;
         bus.iomem_rdata  <= '0;
         err_count        <= '0;
         err_addr         <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  addr_q           <= bus.iomem_addr;
                  bus.periph_addr  <= bus.iomem_addr[7:0];
                  bus.periph_wstrb <= bus.iomem_wstrb;
                  bus.periph_wdata <= bus.iomem_wdata;
                  if (mapped) begin
                     bus.periph_sel <= decode_sel;
                  end else begin
                     bus.iomem_rdata <= ERR_DATA;
                     err_count       <= err_count_next(err_count);
                     err_addr        <= bus.iomem_addr;
                  end
               end
            end
            ST_ACCESS: begin
               // Ready on the last allowed cycle beats the timeout.
               if (hit) begin
                  bus.iomem_rdata <= slot_rdata;
                  bus.periph_sel  <= '0;
               end else if (expired) begin
                  bus.iomem_rdata <= ERR_DATA;
                  bus.periph_sel  <= '0;
                  err_count       <= err_count_next(err_count);
                  err_addr        <= addr_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
